// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned ENTRY_WIDTH       = 2 * INSTRUCTION_WIDTH;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION  = 32'h0000_0013;
  localparam logic [INSTRUCTION_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQUEST = 2'd0,
    WAIT    = 2'd1,
    DROP    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read channel: valid/ready request, single-beat response.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  logic                         memory_request_valid;
  logic                         memory_request_ready;
  logic [INSTRUCTION_WIDTH-1:0] memory_request_address;
  logic                         memory_response_valid;
  logic [INSTRUCTION_WIDTH-1:0] memory_response_data;

  modport master (
    output memory_request_valid,
    output memory_request_address,
    input  memory_request_ready,
    input  memory_response_valid,
    input  memory_response_data
  );

  modport slave (
    input  memory_request_valid,
    input  memory_request_address,
    output memory_request_ready,
    output memory_response_valid,
    output memory_response_data
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instruction} entries; flush beats push.
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH),
  localparam int unsigned COUNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   empty
);

  logic [WIDTH-1:0]     storage [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array needs no reset; reads are masked by empty downstream.
  always_ff @(posedge clock) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

  assign head_data = storage[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner: issues one outstanding word fetch at a time, buffers results for decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  instruction_fetch_unit_if.master       memory,
  input  logic                           redirect_valid,
  input  logic [INSTRUCTION_WIDTH-1:0]   redirect_target,
  output logic                           instruction_valid,
  input  logic                           instruction_ready,
  output logic [INSTRUCTION_WIDTH-1:0]   instruction,
  output logic [INSTRUCTION_WIDTH-1:0]   instruction_pc
);

  localparam int unsigned COUNT_WIDTH = $clog2(BUFFER_DEPTH) + 1;

  fetch_state_t                 state, state_next;
  logic [INSTRUCTION_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [INSTRUCTION_WIDTH-1:0] issued_pc, issued_pc_next;
  logic                         running;
  logic [COUNT_WIDTH-1:0]       count;
  logic                         empty;
  logic                         full_c;
  logic                         push;
  logic                         pop_c;
  logic                         request_valid_c;
  logic                         handshake_c;
  fetch_entry_t                 push_entry;
  fetch_entry_t                 head_entry;

  // running holds off the first request until the edge after reset release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= REQUEST;
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      issued_pc <= issued_pc_next;
      running   <= 1'b1;
    end
  end

  assign full_c          = (count == COUNT_WIDTH'(BUFFER_DEPTH));
  assign request_valid_c = running && (state == REQUEST) && !full_c;
  assign handshake_c     = request_valid_c && memory.memory_request_ready;
  assign pop_c           = !empty && instruction_ready;

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    issued_pc_next = issued_pc;
    push           = 1'b0;
    case (state)
      REQUEST: begin
        if (handshake_c) begin
          issued_pc_next = fetch_pc;
          fetch_pc_next  = fetch_pc + 32'd4;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (memory.memory_response_valid) begin
          push       = 1'b1;
          state_next = REQUEST;
        end
      end
      DROP: begin
        if (memory.memory_response_valid) state_next = REQUEST;
      end
      default: state_next = REQUEST;
    endcase
    // Redirect wins: any accepted or in-flight fetch now belongs to a dead stream
    if (redirect_valid) begin
      push          = 1'b0;
      fetch_pc_next = redirect_target & ~32'h0000_0003;
      if (state == REQUEST) state_next = handshake_c ? DROP : REQUEST;
      else                  state_next = memory.memory_response_valid ? REQUEST : DROP;
    end
  end

  assign push_entry = '{pc: issued_pc, instruction: memory.memory_response_data};

  fetch_buffer #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .count     (count),
    .empty     (empty)
  );

  assign memory.memory_request_valid   = request_valid_c;
  assign memory.memory_request_address = fetch_pc;
  assign instruction_valid             = !empty;
  assign instruction                   = empty ? NOP_INSTRUCTION : head_entry.instruction;
  assign instruction_pc                = empty ? 32'h0000_0000 : head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small latency-configurable memory model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;

  instruction_fetch_unit_if mem_bus ();

  instruction_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .BUFFER_DEPTH (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .memory            (mem_bus),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  int          mem_delay = 0;
  logic [31:0] pop_log [$];

  localparam logic [31:0] WORD_KEY = 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock: drive this cycle's memory response, note handshakes/pops, advance to next negedge.
  task automatic cycle();
    if (pend && pend_wait == 0) begin
      mem_bus.memory_response_valid = 1'b1;
      mem_bus.memory_response_data  = pend_addr ^ WORD_KEY;
      pend = 1'b0;
    end else begin
      mem_bus.memory_response_valid = 1'b0;
      mem_bus.memory_response_data  = '0;
      if (pend) pend_wait--;
    end
    if (!reset && mem_bus.memory_request_valid && mem_bus.memory_request_ready) begin
      pend      = 1'b1;
      pend_addr = mem_bus.memory_request_address;
      pend_wait = mem_delay;
    end
    if (!reset && instruction_valid && instruction_ready) pop_log.push_back(instruction_pc);
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!instruction_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, 32'(instruction_valid), 32'd1);
    check({tag, "_pc"}, instruction_pc, pc);
    check({tag, "_instr"}, instruction, pc ^ WORD_KEY);
  endtask

  task automatic count_pops(input logic [31:0] pc, output int hits);
    hits = 0;
    foreach (pop_log[i]) if (pop_log[i] == pc) hits++;
  endtask

  initial begin
    int hits;
    reset             = 1'b1;
    redirect_valid    = 1'b0;
    redirect_target   = '0;
    instruction_ready = 1'b1;
    mem_bus.memory_request_ready  = 1'b1;
    mem_bus.memory_response_valid = 1'b0;
    mem_bus.memory_response_data  = '0;
    repeat (3) @(negedge clock);

    check("rst_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    check("rst_addr", mem_bus.memory_request_address, 32'h0);
    check("rst_instr_valid", 32'(instruction_valid), 32'd0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", instruction_pc, 32'h0);

    // Streaming from reset with 1-cycle memory
    reset = 1'b0;
    cycle();
    check("c0_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("c0_addr", mem_bus.memory_request_address, 32'h0);
    cycle();
    check("c1_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    check("c1_instr_valid", 32'(instruction_valid), 32'd0);
    cycle();
    check("c2_instr_valid", 32'(instruction_valid), 32'd1);
    check("c2_pc", instruction_pc, 32'h0);
    check("c2_instr", instruction, 32'hDEAD_0000);
    check("c2_addr", mem_bus.memory_request_address, 32'h4);
    cycle();
    check("c3_instr_valid", 32'(instruction_valid), 32'd0);
    cycle();
    check("c4_pc", instruction_pc, 32'h4);
    check("c4_instr_valid", 32'(instruction_valid), 32'd1);

    // Backpressure from decode fills the buffer and stalls requests
    instruction_ready = 1'b0;
    cycle();
    cycle();
    check("full_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    check("full_addr", mem_bus.memory_request_address, 32'hC);
    check("full_head_pc", instruction_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
      check("stall_addr", mem_bus.memory_request_address, 32'hC);
    end
    instruction_ready = 1'b1;
    cycle();
    check("resume_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("resume_addr", mem_bus.memory_request_address, 32'hC);
    check("resume_head_pc", instruction_pc, 32'h8);
    cycle();
    expect_head("seq_c", 32'hC);
    check("pop_count", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      check("pop0", pop_log[0], 32'h0);
      check("pop1", pop_log[1], 32'h4);
      check("pop2", pop_log[2], 32'h8);
    end

    // Redirect in WAIT while the response arrives that same cycle
    cycle();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_1003;
    cycle();
    check("rdw_instr_valid", 32'(instruction_valid), 32'd0);
    check("rdw_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("rdw_addr", mem_bus.memory_request_address, 32'h1000);
    expect_head("rdw_head", 32'h1000);

    // Redirect in WAIT with slow memory: stale response lands in DROP
    mem_delay = 2;
    cycle();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_2000;
    cycle();
    check("drop_req_valid0", 32'(mem_bus.memory_request_valid), 32'd0);
    check("drop_instr_valid", 32'(instruction_valid), 32'd0);
    cycle();
    check("drop_req_valid1", 32'(mem_bus.memory_request_valid), 32'd0);
    cycle();
    check("drop_exit_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("drop_exit_addr", mem_bus.memory_request_address, 32'h2000);
    mem_delay = 0;
    expect_head("drop_head", 32'h2000);

    // Redirect coincident with a request handshake and a pop
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_3000;
    cycle();
    check("rhs_instr_valid", 32'(instruction_valid), 32'd0);
    check("rhs_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    cycle();
    check("rhs_exit_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("rhs_exit_addr", mem_bus.memory_request_address, 32'h3000);
    expect_head("rhs_head", 32'h3000);
    count_pops(32'h2000, hits);
    check("rhs_pop_once", 32'(hits), 32'd1);
    count_pops(32'h2004, hits);
    check("rhs_dropped_2004", 32'(hits), 32'd0);
    count_pops(32'h1004, hits);
    check("drop_dropped_1004", 32'(hits), 32'd0);

    // Memory stall with stable request, then PC wrap at top of address space
    mem_bus.memory_request_ready = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("hold_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
      check("hold_addr", mem_bus.memory_request_address, 32'hFFFF_FFFC);
      cycle();
    end
    mem_bus.memory_request_ready = 1'b1;
    check("hold_last_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    cycle();
    expect_head("wrap_head", 32'hFFFF_FFFC);
    check("wrap_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("wrap_addr", mem_bus.memory_request_address, 32'h0);

    // Reset mid-fetch with a pending response that arrives after release
    instruction_ready = 1'b0;
    mem_delay = 1;
    cycle();
    check("pre_rst_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    check("pre_rst_instr_valid", 32'(instruction_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_req_valid", 32'(mem_bus.memory_request_valid), 32'd0);
    check("arst_instr_valid", 32'(instruction_valid), 32'd0);
    check("arst_instr", instruction, 32'h0000_0013);
    check("arst_pc", instruction_pc, 32'h0);
    check("arst_addr", mem_bus.memory_request_address, 32'h0);
    cycle();
    reset = 1'b0;
    cycle();
    check("late_instr_valid", 32'(instruction_valid), 32'd0);
    check("late_req_valid", 32'(mem_bus.memory_request_valid), 32'd1);
    check("late_addr", mem_bus.memory_request_address, 32'h0);
    mem_delay = 0;
    instruction_ready = 1'b1;
    expect_head("restart_head", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
